// File: rtl/glip_uart_receive.sv
// glip_uart_receive
//   UART receive front end for the GLIP UART backend. Samples the serial rx
//   line, deserialises frames (8N1, or 8E1 when GLIP_UART_RX_PARITY_EN is
//   defined), buffers received bytes in a small FIFO and presents them on a
//   valid/ready byte stream feeding the UART control layer ingress.
//
//   Parameters:
//     FREQ        core clock frequency in Hz
//     BAUD        line baud rate in bit/s (FREQ/BAUD must be >= 4)
//     FIFO_DEPTH  receive buffer entries, power of two, >= 2
//
//   Ports:
//     clk        core clock, rising edge
//     rst        asynchronous active-high reset
//     rx         serial line, idle high, asynchronous to clk
//     out_data   byte at FIFO head
//     out_valid  FIFO non-empty
//     out_ready  consumer accepts out_data this cycle
//     error      sticky framing / overflow / parity fault flag
//
//   Optional feature macro: GLIP_UART_RX_PARITY_EN (even parity bit between
//   the data bits and the stop bit).
module glip_uart_receive #(
  parameter logic [31:0] FREQ       = 32'd50000000,
  parameter logic [31:0] BAUD       = 32'd115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       error
);

  localparam logic [31:0] DIVISOR = FREQ / BAUD;
  localparam int unsigned CW      = $clog2(DIVISOR) + 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(DIVISOR / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIVISOR - 1);

  generate
    if (DIVISOR < 4) begin : g_div_check
      $error("glip_uart_receive: FREQ/BAUD must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
      $error("glip_uart_receive: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef GLIP_UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser; flops reset to 1 so reset looks like an idle line
  // ---------------------------------------------------------------------
  logic rx_q1, rx_s, rx_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      rx_q1  <= rx;
      rx_s   <= rx_q1;
      rx_s_d <= rx_s;
    end
  end

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          stop_ok;   // valid stop bit seen, byte ready to push
  logic          line_err;  // framing or parity fault this cycle
`ifdef GLIP_UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
`ifdef GLIP_UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
`ifdef GLIP_UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    line_err  = 1'b0;
`ifdef GLIP_UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (rx_s_d && !rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            // start bit vanished before mid-bit: treat as a glitch
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'd7) begin
`ifdef GLIP_UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef GLIP_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == '0) begin
          par_bad_d = rx_s ^ (^shift_q);
          line_err  = par_bad_d;
          cnt_d     = FULL_LOAD;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      STOP: begin
        if (cnt_q == '0) begin
          // leave mid stop bit so the next start edge is never missed
          state_d = IDLE;
          if (rx_s) begin
`ifdef GLIP_UART_RX_PARITY_EN
            stop_ok = !par_bad_q;
`else
            stop_ok = 1'b1;
`endif
          end else begin
            line_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Receive FIFO; one extra pointer bit separates full from empty
  // ---------------------------------------------------------------------
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        empty, full, push, pop, overflow;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop       = out_valid && out_ready;
  assign push      = stop_ok && (!full || pop);
  assign overflow  = stop_ok && full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sticky error
  // ---------------------------------------------------------------------
  logic error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q <= 1'b0;
    end else if (line_err || overflow) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_glip_uart_receive.sv
// Directed testbench for glip_uart_receive with FREQ=8, BAUD=1 (8 clocks
// per bit). Inputs change 1 time unit after a rising edge; a negedge
// monitor records every accepted byte and the cycle it was accepted in.
module tb_glip_uart_receive;

  localparam int unsigned DIV = 8;
`ifdef GLIP_UART_RX_PARITY_EN
  localparam int unsigned LAT = 87;
`else
  localparam int unsigned LAT = 79;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       error;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  logic [7:0]  pop_q[$];
  int unsigned pop_cyc[$];

  glip_uart_receive #(
    .FREQ(32'd8),
    .BAUD(32'd1),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      pop_q.push_back(out_data);
      pop_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    pop_q.delete();
    pop_cyc.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(DIV);
    end
`ifdef GLIP_UART_RX_PARITY_EN
    rx = ^d;
    tick(DIV);
`endif
    rx = stop_bit;
    tick(DIV);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    rst = 1'b0;
    tick(5);
  endtask

  task automatic test_single();
    int unsigned c0;
    logic [7:0] got;
    int unsigned got_c;
    out_ready = 1'b1;
    clear_q();
    c0 = cyc;
    send_frame(8'hA5, 1'b1);
    tick(12);
    got   = (pop_q.size() > 0) ? pop_q[0] : 8'hxx;
    got_c = (pop_cyc.size() > 0) ? pop_cyc[0] : 0;
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d want=1", pop_q.size()); end
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", got); end
    total++; if (got_c !== c0 + LAT) begin bad++; $display("FAIL single_latency got=%0d want=%0d", got_c - c0, LAT); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL single_error got=%b want=0", error); end
  endtask

  task automatic test_glitch();
    logic [7:0] got;
    out_ready = 1'b1;
    clear_q();
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(20);
    total++; if (pop_q.size() !== 0) begin bad++; $display("FAIL glitch_count got=%0d want=0", pop_q.size()); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL glitch_error got=%b want=0", error); end
    send_frame(8'h96, 1'b1);
    tick(12);
    got = (pop_q.size() > 0) ? pop_q[0] : 8'hxx;
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL glitch_next_count got=%0d want=1", pop_q.size()); end
    total++; if (got !== 8'h96) begin bad++; $display("FAIL glitch_next_data got=%h want=96", got); end
  endtask

  task automatic test_framing();
    logic [7:0] got;
    out_ready = 1'b1;
    clear_q();
    send_frame(8'h3C, 1'b0);
    tick(12);
    total++; if (pop_q.size() !== 0) begin bad++; $display("FAIL framing_count got=%0d want=0", pop_q.size()); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL framing_error got=%b want=1", error); end
    send_frame(8'h7E, 1'b1);
    tick(12);
    got = (pop_q.size() > 0) ? pop_q[0] : 8'hxx;
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL framing_next_count got=%0d want=1", pop_q.size()); end
    total++; if (got !== 8'h7E) begin bad++; $display("FAIL framing_next_data got=%h want=7e", got); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL framing_sticky got=%b want=1", error); end
  endtask

  task automatic test_async_reset();
    logic [7:0] got;
    out_ready = 1'b0;
    clear_q();
    send_frame(8'h11, 1'b1);
    tick(12);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL arst_pre_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL arst_pre_data got=%h want=11", out_data); end
    // start 0x22 and abort it inside the data bits
    rx = 1'b0; tick(DIV);
    rx = 1'b0; tick(DIV);
    rx = 1'b1; tick(DIV);
    #2;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b want=0", out_valid); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL arst_error got=%b want=0", error); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL arst_data got=%h want=00", out_data); end
    rx = 1'b0; tick(4);
    rx = 1'b1; tick(3);
    rx = 1'b0; tick(5);
    rx = 1'b1; tick(2);
    rst = 1'b0;
    tick(10);
    out_ready = 1'b1;
    clear_q();
    send_frame(8'h55, 1'b1);
    tick(12);
    got = (pop_q.size() > 0) ? pop_q[0] : 8'hxx;
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL arst_next_count got=%0d want=1", pop_q.size()); end
    total++; if (got !== 8'h55) begin bad++; $display("FAIL arst_next_data got=%h want=55", got); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL arst_next_error got=%b want=0", error); end
  endtask

`ifdef GLIP_UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] got;
    out_ready = 1'b1;
    clear_q();
    send_frame(8'h03, 1'b1);
    tick(12);
    got = (pop_q.size() > 0) ? pop_q[0] : 8'hxx;
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL parity_ok_count got=%0d want=1", pop_q.size()); end
    total++; if (got !== 8'h03) begin bad++; $display("FAIL parity_ok_data got=%h want=03", got); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL parity_ok_error got=%b want=0", error); end
    // 0x03 with a wrong (odd) parity bit
    rx = 1'b0; tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = (i < 2) ? 1'b1 : 1'b0;
      tick(DIV);
    end
    rx = 1'b1; tick(DIV);
    rx = 1'b1; tick(DIV);
    tick(12);
    total++; if (pop_q.size() !== 1) begin bad++; $display("FAIL parity_bad_count got=%0d want=1", pop_q.size()); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL parity_bad_error got=%b want=1", error); end
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] exp_b;
    logic [7:0] got;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    out_ready = 1'b0;
    clear_q();
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      tick(4);
      total++; if (out_data !== 8'h01) begin bad++; $display("FAIL ovf_hold_%0d got=%h want=01", i, out_data); end
      if (i == 4) begin
        total++; if (error !== 1'b0) begin bad++; $display("FAIL ovf_full_error got=%b want=0", error); end
      end
    end
    tick(8);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", out_valid); end
    total++; if (error !== 1'b1) begin bad++; $display("FAIL ovf_error got=%b want=1", error); end
    out_ready = 1'b1;
    tick(8);
    total++; if (pop_q.size() !== 4) begin bad++; $display("FAIL ovf_drain_count got=%0d want=4", pop_q.size()); end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'(i + 1);
      got   = (pop_q.size() > i) ? pop_q[i] : 8'hxx;
      total++; if (got !== exp_b) begin bad++; $display("FAIL ovf_drain_%0d got=%h want=%h", i, got, exp_b); end
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%b want=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_async_reset();
`ifdef GLIP_UART_RX_PARITY_EN
    test_parity();
`endif
    test_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
